pwm_generator: RTL and testbench

PWM_GENERATOR -- requirements
Module: pwm_generator

---
 rtl/pwm_pkg.sv | 6 +
 rtl/pwm_prescaler.sv | 35 +++
 rtl/pwm_generator.sv | 111 +++++++++++
 tb/tb_pwm_generator.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM generator slice.
package pwm_pkg;
   localparam int             PWM_CNT_W        = 8;
   localparam logic [7:0]     DUTY_FULL        = 8'hFF;
   localparam int             PRESCALE_DEFAULT = 12;
endpackage

// File: rtl/pwm_prescaler.sv
// Prescaler for the PWM counter.
// Counts 0..PRESCALE-1 and wraps; tick is high for the one clk in which the
// count equals PRESCALE-1.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   tick  - one-clk strobe, once every PRESCALE clk
module pwm_prescaler
   import pwm_pkg::*;
#(
   parameter int PRESCALE = PRESCALE_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int PSC_W = 16;
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

   logic [PSC_W-1:0] psc_q;

   assign tick = (psc_q == PSC_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psc_q <= '0;
      end else if (tick) begin
         psc_q <= '0;
      end else begin
         psc_q <= psc_q + 1'b1;
      end
   end

endmodule

// File: rtl/pwm_generator.sv
// 16-channel PWM / static output driver sharing one duty value.
// Each out[i] is 0 when disabled, the PWM level when PWM-selected, else 1.
// Outputs are registered (one clk from counter/config change to pin).
// Optional macro PWM_SHADOW_UPDATE_EN: duty, enables and selects are captured
// into shadow registers at the 255->0 counter wrap (and on the first clk after
// reset), so configuration changes only take effect at period boundaries.
// Ports:
//   clk                - system clock
//   rst_n              - asynchronous active-low reset
//   en_reg_out_7_0     - output enable, out[7:0]
//   en_reg_out_15_8    - output enable, out[15:8]
//   en_reg_pwm_7_0     - PWM-mode select, out[7:0]
//   en_reg_pwm_15_8    - PWM-mode select, out[15:8]
//   pwm_duty_cycle     - shared duty value
//   out                - registered drive outputs
module pwm_generator
   import pwm_pkg::*;
#(
   parameter int PRESCALE = PRESCALE_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           en_reg_out_7_0,
   input  logic [7:0]           en_reg_out_15_8,
   input  logic [7:0]           en_reg_pwm_7_0,
   input  logic [7:0]           en_reg_pwm_15_8,
   input  logic [PWM_CNT_W-1:0] pwm_duty_cycle,
   output logic [15:0]          out
);

   logic                 tick;
   logic                 wrap;
   logic [PWM_CNT_W-1:0] cnt_q;
   logic [15:0]          en_live, sel_live;
   logic [15:0]          en_eff, sel_eff;
   logic [PWM_CNT_W-1:0] duty_eff;
   logic                 pwm_level;
   logic [15:0]          out_d;

   assign en_live  = {en_reg_out_15_8, en_reg_out_7_0};
   assign sel_live = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Tick on which the counter rolls over 255 -> 0.
   assign wrap = tick && (cnt_q == {PWM_CNT_W{1'b1}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

`ifdef PWM_SHADOW_UPDATE_EN
   logic                 load_pending_q;
   logic [15:0]          en_sh_q, sel_sh_q;
   logic [PWM_CNT_W-1:0] duty_sh_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_pending_q <= 1'b1;
         en_sh_q        <= '0;
         sel_sh_q       <= '0;
         duty_sh_q      <= '0;
      end else begin
         load_pending_q <= 1'b0;
         if (load_pending_q || wrap) begin
            en_sh_q   <= en_live;
            sel_sh_q  <= sel_live;
            duty_sh_q <= pwm_duty_cycle;
         end
      end
   end

   // During the first clk after reset the shadows are still empty, so the
   // live values drive the compare directly; period 0 then uses live config.
   assign en_eff   = load_pending_q ? en_live        : en_sh_q;
   assign sel_eff  = load_pending_q ? sel_live       : sel_sh_q;
   assign duty_eff = load_pending_q ? pwm_duty_cycle : duty_sh_q;
`else
   assign en_eff   = en_live;
   assign sel_eff  = sel_live;
   assign duty_eff = pwm_duty_cycle;
`endif

   always_comb begin
      pwm_level = 1'b0;
      if (duty_eff == DUTY_FULL) begin
         pwm_level = 1'b1;
      end else begin
         pwm_level = (cnt_q < duty_eff);
      end
   end

   assign out_d = en_eff & ((sel_eff & {16{pwm_level}}) | ~sel_eff);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= '0;
      end else begin
         out <= out_d;
      end
   end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator with PRESCALE = 2 (512-clk period).
// After reset release at a negedge, the PWM counter value seen at posedge n
// (n = 1, 2, ...) is (n-1)/2, so out after edge n reflects that value.
module tb_pwm_generator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  en_reg_out_7_0  = '0;
   logic [7:0]  en_reg_out_15_8 = '0;
   logic [7:0]  en_reg_pwm_7_0  = '0;
   logic [7:0]  en_reg_pwm_15_8 = '0;
   logic [7:0]  pwm_duty_cycle  = '0;
   logic [15:0] out;

   int n_checks = 0;
   int n_fail   = 0;
   int hi, bad;

   always #5 clk = ~clk;

   pwm_generator #(.PRESCALE(2)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .out             (out)
   );

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_cfg(input logic [15:0] en, input logic [15:0] sel,
                          input logic [7:0] duty);
      en_reg_out_15_8 = en[15:8];
      en_reg_out_7_0  = en[7:0];
      en_reg_pwm_15_8 = sel[15:8];
      en_reg_pwm_7_0  = sel[7:0];
      pwm_duty_cycle  = duty;
   endtask

   // Hold reset, apply config, release at a negedge.
   task automatic restart(input logic [15:0] en, input logic [15:0] sel,
                          input logic [7:0] duty);
      @(negedge clk);
      rst_n = 1'b0;
      set_cfg(en, sel, duty);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Sample out #1 after each of n posedges; count samples equal to hi_pat,
   // and samples equal to neither hi_pat nor lo_pat.
   task automatic run_count(input int n, input logic [15:0] hi_pat,
                            input logic [15:0] lo_pat,
                            output int n_hi, output int n_bad);
      n_hi  = 0;
      n_bad = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (out === hi_pat) n_hi++;
         else if (out !== lo_pat) n_bad++;
      end
   endtask

   initial begin
      // Reset state
      #2;
      check_val("reset_out", out, 32'h0000);

      // Static drive
      set_cfg(16'hFFFF, 16'h0000, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("static_first_clk", out, 32'hFFFF);
      run_count(300, 16'hFFFF, 16'hFFFF, hi, bad);
      check_val("static_hold", hi, 300);

      // Asynchronous reset mid-period
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_val("async_reset_out", out, 32'h0000);
      @(posedge clk);
      #1;
      check_val("reset_held_out", out, 32'h0000);

      // 50% duty on bit 0; phase proves counter restarted at 0
      restart(16'h0001, 16'h0001, 8'h80);
      run_count(256, 16'h0001, 16'h0000, hi, bad);
      check_val("duty80_first_half_hi", hi, 256);
      run_count(256, 16'h0001, 16'h0000, hi, bad);
      check_val("duty80_second_half_hi", hi, 0);
      check_val("duty80_second_half_bad", bad, 0);
      run_count(1024, 16'h0001, 16'h0000, hi, bad);
      check_val("duty80_two_periods_hi", hi, 512);
      check_val("duty80_two_periods_bad", bad, 0);

      // Duty extremes
      restart(16'h0001, 16'h0001, 8'h00);
      run_count(1536, 16'h0001, 16'h0000, hi, bad);
      check_val("duty00_hi", hi, 0);
      check_val("duty00_bad", bad, 0);
      restart(16'h0001, 16'h0001, 8'hFF);
      run_count(1536, 16'h0001, 16'h0000, hi, bad);
      check_val("dutyFF_hi", hi, 1536);
      check_val("dutyFF_bad", bad, 0);

      // Mixed static/PWM bits, 25% duty
      restart(16'hA5A5, 16'h00FF, 8'h40);
      run_count(128, 16'hA5A5, 16'hA500, hi, bad);
      check_val("mixed_on_phase_hi", hi, 128);
      run_count(384, 16'hA5A5, 16'hA500, hi, bad);
      check_val("mixed_off_phase_hi", hi, 0);
      check_val("mixed_off_phase_bad", bad, 0);

      // Duty change 0x40 -> 0xC0 while counter is 100 (edges 201/202)
      restart(16'h0001, 16'h0001, 8'h40);
      run_count(200, 16'h0001, 16'h0000, hi, bad);
      check_val("chg_before_hi", hi, 128);
      pwm_duty_cycle = 8'hC0;
      run_count(1, 16'h0001, 16'h0000, hi, bad);
`ifdef PWM_SHADOW_UPDATE_EN
      check_val("chg_next_clk", out, 32'h0000);
      run_count(311, 16'h0001, 16'h0000, hi, bad);
      check_val("chg_rest_of_period_hi", hi, 0);
`else
      check_val("chg_next_clk", out, 32'h0001);
      run_count(311, 16'h0001, 16'h0000, hi, bad);
      check_val("chg_rest_of_period_hi", hi, 183);
`endif
      run_count(384, 16'h0001, 16'h0000, hi, bad);
      check_val("chg_next_period_on_hi", hi, 384);
      run_count(128, 16'h0001, 16'h0000, hi, bad);
      check_val("chg_next_period_off_hi", hi, 0);
      check_val("chg_next_period_bad", bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
